// File: rtl/pixel_write_packer.sv
// Packs 8-bit pixels little-endian into 32-bit words, buffers them in a small FIFO and
// streams them to SDRAM as single-word Avalon-MM writes at consecutive addresses.
module pixel_write_packer #(
  parameter int unsigned ADDRWIDTH  = 32,
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNTWIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDRWIDTH-1:0]   base_addr,
  input  logic [CNTWIDTH-1:0]    pixel_count,
  input  logic                   pix_valid,
  input  logic [7:0]             pix_data,
  output logic                   pix_ready,
  output logic [ADDRWIDTH-1:0]   master_address,
  output logic                   master_write,
  output logic [DATAWIDTH-1:0]   master_writedata,
  output logic [DATAWIDTH/8-1:0] master_byteenable,
  input  logic                   master_waitrequest,
  output logic                   busy,
  output logic                   done,
  output logic [CNTWIDTH-1:0]    words_written
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BeW  = DATAWIDTH / 8;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [CNTWIDTH-1:0]    count_q, count_d;
  logic [CNTWIDTH-1:0]    acc_q, acc_d, acc_inc;
  logic [CNTWIDTH-1:0]    ww_q, ww_d;
  logic [DATAWIDTH-1:0]   pack_q, pack_d, new_word;
  logic [1:0]             idx_q, idx_d;
  logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATAWIDTH-1:0]   mem_data_q [FIFO_DEPTH];
  logic [BeW-1:0]         mem_be_q [FIFO_DEPTH];
  logic [BeW-1:0]         new_be;
  logic                   fifo_empty, fifo_full, last_pix, completes;
  logic                   accept, push, pop;

  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                 (wptr_q[PtrW-2:0] == rptr_q[PtrW-2:0]);
    acc_inc    = acc_q + 1'b1;
    last_pix   = (acc_inc == count_q);
    completes  = (idx_q == 2'd3) || last_pix;
    // A pixel that does not complete a word only needs the pack register, not a FIFO slot.
    pix_ready    = (state_q == StRun) && (acc_q < count_q) && (!fifo_full || !completes);
    accept       = pix_valid && pix_ready;
    push         = accept && completes;
    master_write = !fifo_empty && ((state_q == StRun) || (state_q == StDrain));
    pop          = master_write && !master_waitrequest;

    new_word = pack_q;
    new_word[{idx_q, 3'b000} +: 8] = pix_data;
    unique case (idx_q)
      2'd0:    new_be = BeW'(4'b0001);
      2'd1:    new_be = BeW'(4'b0011);
      2'd2:    new_be = BeW'(4'b0111);
      default: new_be = BeW'(4'b1111);
    endcase
  end

  always_comb begin
    master_address    = addr_q;
    master_writedata  = master_write ? mem_data_q[rptr_q[PtrW-2:0]] : '0;
    master_byteenable = master_write ? mem_be_q[rptr_q[PtrW-2:0]] : '0;
    busy              = (state_q != StIdle);
    done              = (state_q == StDone);
    words_written     = ww_q;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    acc_d   = acc_q;
    ww_d    = ww_q;
    pack_d  = pack_q;
    idx_d   = idx_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;

    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      addr_d = addr_q + ADDRWIDTH'(4);
      ww_d   = ww_q + 1'b1;
    end
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (accept) begin
      acc_d = acc_inc;
      if (completes) begin
        pack_d = '0;
        idx_d  = '0;
      end else begin
        pack_d = new_word;
        idx_d  = idx_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d = pixel_count;
          acc_d   = '0;
          ww_d    = '0;
          pack_d  = '0;
          idx_d   = '0;
          addr_d  = {base_addr[ADDRWIDTH-1:2], 2'b00};
          state_d = (pixel_count == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept && last_pix) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      acc_q   <= '0;
      ww_q    <= '0;
      pack_q  <= '0;
      idx_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      ww_q    <= ww_d;
      pack_q  <= pack_d;
      idx_q   <= idx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage needs no reset: the head is only presented while the pointers say it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wptr_q[PtrW-2:0]] <= new_word;
      mem_be_q[wptr_q[PtrW-2:0]]   <= new_be;
    end
  end

endmodule

// File: tb/tb_pixel_write_packer.sv
// Randomised bench for pixel_write_packer: a queue-based job model is compared with the DUT
// every cycle, and directed jobs pin the model with hand-computed words and addresses.
module tb_pixel_write_packer;

  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] base_addr;
  logic [23:0] pixel_count;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [3:0]  master_byteenable;
  logic        master_waitrequest;
  logic        busy;
  logic        done;
  logic [23:0] words_written;

  pixel_write_packer #(
    .ADDRWIDTH (32),
    .DATAWIDTH (32),
    .FIFO_DEPTH(Depth),
    .CNTWIDTH  (24)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .pixel_count       (pixel_count),
    .pix_valid         (pix_valid),
    .pix_data          (pix_data),
    .pix_ready         (pix_ready),
    .master_address    (master_address),
    .master_write      (master_write),
    .master_writedata  (master_writedata),
    .master_byteenable (master_byteenable),
    .master_waitrequest(master_waitrequest),
    .busy              (busy),
    .done              (done),
    .words_written     (words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] data; logic [3:0] be;} word_t;
  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] be;} wr_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Job model: phase 0 idle, 1 run, 2 drain, 3 done.
  int          m_phase;
  logic [31:0] m_addr;
  int          m_count, m_acc, m_ww;
  word_t       m_q[$];
  logic [7:0]  m_bytes[$];
  logic        exp_ready, exp_wr, pop_now, acc_now;
  bit          seen_rst = 0;
  word_t       w;

  wr_t         wr_log[$];
  int          done_cnt;
  logic [7:0]  pix_q[$];

  always @(negedge clk) begin
    if (seen_rst) begin
      exp_ready = (m_phase == 1) && (m_acc < m_count) &&
                  ((m_q.size() < Depth) || ((m_bytes.size() < 3) && (m_acc + 1 < m_count)));
      exp_wr    = ((m_phase == 1) || (m_phase == 2)) && (m_q.size() > 0);
      chk("pix_ready", pix_ready, exp_ready);
      chk("master_write", master_write, exp_wr);
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_phase == 3);
      chk("words_written", words_written, m_ww);
      chk("master_address", master_address, m_addr);
      if (exp_wr) begin
        chk("writedata", master_writedata, m_q[0].data);
        chk("byteenable", master_byteenable, m_q[0].be);
      end
      if (reset_n && master_write && !master_waitrequest)
        wr_log.push_back('{master_address, master_writedata, master_byteenable});
      if (reset_n && done) done_cnt++;
    end

    if (!reset_n) begin
      m_phase = 0; m_addr = '0; m_count = 0; m_acc = 0; m_ww = 0;
      m_q.delete(); m_bytes.delete();
      seen_rst = 1;
    end else if (seen_rst) begin
      pop_now = exp_wr && !master_waitrequest;
      acc_now = pix_valid && exp_ready;
      case (m_phase)
        0: if (start) begin
          m_count = int'(pixel_count); m_acc = 0; m_ww = 0;
          m_addr = {base_addr[31:2], 2'b00};
          m_bytes.delete();
          m_phase = (m_count == 0) ? 3 : 1;
        end
        1, 2: begin
          if (m_phase == 2 && m_q.size() == 0) m_phase = 3;
          if (pop_now) begin
            void'(m_q.pop_front());
            m_addr += 32'd4;
            m_ww++;
          end
          if (acc_now) begin
            m_bytes.push_back(pix_data);
            m_acc++;
            if (m_bytes.size() == 4 || m_acc == m_count) begin
              w.data = '0;
              for (int k = 0; k < m_bytes.size(); k++) w.data[8*k +: 8] = m_bytes[k];
              w.be = 4'((1 << m_bytes.size()) - 1);
              m_q.push_back(w);
              m_bytes.delete();
              if (m_acc == m_count) m_phase = 2;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic run_job(input logic [31:0] base, input int n, input int vpct, input int wpct,
                         input int stall, input int restart_at);
    int pi = 0;
    int cyc = 0;
    bit took;
    wr_log.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    base_addr = base; pixel_count = 24'(n); start = 1'b1;
    master_waitrequest = (stall > 0);
    @(posedge clk); #1;
    start = 1'b0;
    pix_valid = (n > 0) && ($urandom_range(99) < vpct);
    pix_data  = (n > 0) ? pix_q[0] : 8'h00;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk);
      took = pix_valid && pix_ready;
      @(posedge clk); #1;
      cyc++;
      if (took) pi++;
      if (stall > 0 && cyc == stall) begin
        chk("bp_accepted", pi, 35);
        chk("bp_ready_low", pix_ready, 1'b0);
      end
      start = (restart_at > 0) && (cyc == restart_at);
      if (start) begin
        base_addr = 32'h0000_9000; pixel_count = 24'd3;
      end
      pix_valid = (pi < n) && ($urandom_range(99) < vpct);
      pix_data  = (pi < n) ? pix_q[pi] : 8'($urandom);
      master_waitrequest = (cyc < stall) ? 1'b1 : ($urandom_range(99) < wpct);
    end
    chk("job_done_pulse", done_cnt, 1);
    pix_valid = 1'b0;
    start = 1'b0;
    master_waitrequest = 1'b0;
  endtask

  task automatic check_totals(input logic [31:0] base, input int n);
    int nw = (n + 3) / 4;
    logic [31:0] last;
    last = {base[31:2], 2'b00} + 32'(4 * (nw - 1));
    chk("total_writes", wr_log.size(), nw);
    chk("total_words_written", words_written, nw);
    if (wr_log.size() > 0) chk("last_address", wr_log[wr_log.size()-1].addr, last);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b;
    int n;
    int pi;
    bit took;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; pixel_count = '0;
    pix_valid = 1'b0; pix_data = '0; master_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_write", master_write, 1'b0);
    chk("rst_address", master_address, 32'h0);
    chk("rst_writedata", master_writedata, 32'h0);
    chk("rst_byteenable", master_byteenable, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_words", words_written, 24'h0);
    reset_n = 1'b1;

    // Aligned job, no backpressure.
    pix_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_job(32'h0850_0000, 8, 100, 0, 0, 0);
    chk("aligned_nwrites", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("aligned_w0", wr_log[0], {32'h0850_0000, 32'h4433_2211, 4'hF});
      chk("aligned_w1", wr_log[1], {32'h0850_0004, 32'h8877_6655, 4'hF});
    end
    chk("aligned_words", words_written, 24'd2);

    // Partial final word.
    pix_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_job(32'h0000_1000, 6, 100, 0, 0, 0);
    chk("partial_nwrites", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("partial_w0", wr_log[0], {32'h0000_1000, 32'h0403_0201, 4'hF});
      chk("partial_w1", wr_log[1], {32'h0000_1004, 32'h0000_0605, 4'b0011});
    end

    // Backpressure: 60 stalled cycles, 40 pixels offered continuously.
    pix_q.delete();
    for (int i = 0; i < 40; i++) pix_q.push_back(8'(i + 1));
    run_job(32'h0010_0000, 40, 100, 0, 60, 0);
    chk("bp_nwrites", wr_log.size(), 10);
    for (int k = 0; k < wr_log.size() && k < 10; k++)
      chk("bp_word", wr_log[k], {32'h0010_0000 + 32'(4 * k),
          pix_q[4*k+3], pix_q[4*k+2], pix_q[4*k+1], pix_q[4*k], 4'hF});

    // Zero-length job.
    @(posedge clk); #1;
    base_addr = 32'h0000_5000; pixel_count = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done_hi", done, 1'b1);
    chk("zero_busy_hi", busy, 1'b1);
    chk("zero_no_write0", master_write, 1'b0);
    @(posedge clk); #1;
    chk("zero_done_lo", done, 1'b0);
    chk("zero_busy_lo", busy, 1'b0);
    chk("zero_no_write1", master_write, 1'b0);

    // Start while busy is ignored.
    pix_q.delete();
    for (int i = 0; i < 12; i++) pix_q.push_back(8'($urandom));
    run_job(32'h0000_2000, 12, 100, 30, 0, 4);
    chk("restart_nwrites", wr_log.size(), 3);
    for (int k = 0; k < wr_log.size() && k < 3; k++)
      chk("restart_addr", wr_log[k].addr, 32'h0000_2000 + 32'(4 * k));

    // Reset during a stalled write.
    pix_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    master_waitrequest = 1'b1;
    @(posedge clk); #1;
    base_addr = 32'h0000_4000; pixel_count = 24'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pix_valid = 1'b1; pi = 0; pix_data = pix_q[0];
    repeat (6) begin
      @(negedge clk);
      took = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (took) pi++;
      pix_data = (pi < 8) ? pix_q[pi] : 8'h00;
    end
    chk("rst_mid_pre_write", master_write, 1'b1);
    reset_n = 1'b0; pix_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_write", master_write, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_words", words_written, 24'd0);
    reset_n = 1'b1; master_waitrequest = 1'b0;
    pix_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_job(32'h0000_0300, 5, 70, 40, 0, 0);
    chk("post_rst_nwrites", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("post_rst_w0", wr_log[0], {32'h0000_0300, 32'hA4A3_A2A1, 4'hF});
      chk("post_rst_w1", wr_log[1], {32'h0000_0304, 32'h0000_00A5, 4'b0001});
    end

    // Address wrap, unaligned base.
    pix_q.delete();
    for (int i = 0; i < 20; i++) pix_q.push_back(8'($urandom));
    run_job(32'hFFFF_FFF2, 20, 80, 20, 0, 0);
    check_totals(32'hFFFF_FFF2, 20);

    // Random jobs.
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(1, 30);
      b = $urandom;
      pix_q.delete();
      for (int i = 0; i < n; i++) pix_q.push_back(8'($urandom_range(0, 255)));
      run_job(b, n, $urandom_range(30, 100), $urandom_range(0, 70), 0, 0);
      check_totals(b, n);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
